// File: rtl/avalon_burst_responder.sv
// Avalon-MM burst responder backed by a simple dual-port word memory.
// Bus port A (burst read/write), local read port B, doorbell irq.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   address/read/write/...   Avalon-MM slave (burstcount, waitrequest,
//                            readdata, readdatavalid)
//   local_addr/local_rdata   registered local read port
//   irq/irq_ack              doorbell on writes to the last word
module avalon_burst_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_BITS   = 8,
  parameter int BURST_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            address,
  input  logic                   read,
  input  logic                   write,
  input  logic [DATA_WIDTH-1:0]  writedata,
  input  logic [BURST_WIDTH-1:0] burstcount,
  output logic                   waitrequest,
  output logic [DATA_WIDTH-1:0]  readdata,
  output logic                   readdatavalid,
  input  logic [ADDR_BITS-1:0]   local_addr,
  output logic [DATA_WIDTH-1:0]  local_rdata,
  output logic                   irq,
  input  logic                   irq_ack
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_BITS-1:0]   r_ptr;
  logic [BURST_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic                   r_rdv;
  logic [DATA_WIDTH-1:0]  r_local;
  logic                   r_irq;

  logic [ADDR_BITS-1:0]   w_idx;
  logic [BURST_WIDTH-1:0] w_len;
  logic                   w_wr_en;
  logic [ADDR_BITS-1:0]   w_wr_addr;
  logic                   w_rd_issue;
  logic                   w_irq_set;
  logic                   w_unused;

  assign w_idx    = address[ADDR_BITS+1:2];
  assign w_unused = ^{address[31:ADDR_BITS+2],
                      address[1:0]};

  // burstcount of zero means a single beat
  assign w_len = (burstcount == '0) ?
                 BURST_WIDTH'(1) : burstcount;

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_ptr;
    case (r_state)
      IDLE: begin
        w_wr_en   = write;
        w_wr_addr = w_idx;
      end
      WR_BURST: w_wr_en = write;
      default: ;
    endcase
  end

  // r_cnt counts reads still to issue; the burst
  // ends once all are issued and the last is on the bus
  assign w_rd_issue = (r_state == RD_BURST) &&
                      (r_cnt != '0);

  assign w_irq_set = w_wr_en &&
                     (w_wr_addr == ADDR_BITS'(DEPTH-1));

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (write) begin
          if (w_len != BURST_WIDTH'(1))
            w_next = WR_BURST;
        end else if (read) begin
          w_next = RD_BURST;
        end
      end
      WR_BURST: begin
        if (write && r_cnt == BURST_WIDTH'(1))
          w_next = IDLE;
      end
      RD_BURST: begin
        if (r_cnt == '0) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // outputs: stall while reading or held in reset
  always_comb begin
    waitrequest = !reset_n ||
                  (r_state == RD_BURST);
  end

  // burst pointer and beat counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (write) begin
            r_ptr <= w_idx + 1'b1;
            r_cnt <= w_len - 1'b1;
          end else if (read) begin
            r_ptr <= w_idx;
            r_cnt <= w_len;
          end
        end
        WR_BURST: begin
          if (write) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RD_BURST: begin
          if (w_rd_issue) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // memory contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= writedata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_rdv   <= 1'b0;
      r_local <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_rdv <= w_rd_issue;
      if (w_rd_issue) r_rdata <= r_mem[r_ptr];
      r_local <= r_mem[local_addr];
      r_irq   <= w_irq_set | (r_irq & ~irq_ack);
    end
  end

  assign readdata      = r_rdata;
  assign readdatavalid = r_rdv;
  assign local_rdata   = r_local;
  assign irq           = r_irq;

endmodule

// File: tb/tb_avalon_burst_responder.sv
// Scoreboard bench for avalon_burst_responder.
// Expected read beats are queued with data and cycle.
module tb_avalon_burst_responder;

  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [4:0]  burstcount;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [7:0]  local_addr;
  logic [31:0] local_rdata;
  logic        irq;
  logic        irq_ack;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          n_pop = 0;
  int          n_rdv = 0;
  logic        irq_m;
  logic [31:0] mdl [DEPTH];
  exp_t        exp_q [$];
  exp_t        m_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  avalon_burst_responder #(
    .DATA_WIDTH (32),
    .ADDR_BITS  (8),
    .BURST_WIDTH(5)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .burstcount   (burstcount),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .local_addr   (local_addr),
    .local_rdata  (local_rdata),
    .irq          (irq),
    .irq_ack      (irq_ack)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 &&
        readdatavalid === 1'b1) begin
      n_rdv++;
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        m_e = exp_q.pop_front();
        check("rd_data", readdata, m_e.d);
        check("rd_cycle", cyc, m_e.c);
        n_pop++;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int word,
                           input int n,
                           input logic [31:0] v0,
                           input logic [31:0] dv,
                           input int stall_after);
    int ne;
    int idx;
    ne = (n == 0) ? 1 : n;
    address    = 32'(word) << 2;
    burstcount = 5'(n);
    write      = 1'b1;
    for (int i = 0; i < ne; i++) begin
      idx       = (word + i) % DEPTH;
      writedata = v0 + 32'(i) * dv;
      mdl[idx]  = writedata;
      check("wr_wait", waitrequest, 32'd0);
      step;
      if (idx == DEPTH - 1) irq_m = 1'b1;
      check("wr_irq", irq, irq_m);
      if (i + 1 == stall_after && i + 1 < ne) begin
        write = 1'b0;
        step;
        write = 1'b1;
      end
    end
    write = 1'b0;
  endtask

  task automatic bus_read(input int word,
                          input int n);
    int   ne;
    int   ct;
    int   w;
    exp_t e;
    ne = (n == 0) ? 1 : n;
    address    = 32'(word) << 2;
    burstcount = 5'(n);
    read       = 1'b1;
    check("rd_accept", waitrequest, 32'd0);
    step;
    read = 1'b0;
    ct   = cyc;
    for (int i = 0; i < ne; i++) begin
      e.d = mdl[(word + i) % DEPTH];
      e.c = ct + 1 + i;
      exp_q.push_back(e);
    end
    w = 0;
    while (waitrequest === 1'b1 && w < 200) begin
      w++;
      step;
    end
    check("rd_wait_cycles", w, ne + 1);
    check("rd_drained", exp_q.size(), 32'd0);
  endtask

  task automatic local_chk(input int word);
    local_addr = 8'(word);
    step;
    check("local", local_rdata, mdl[word]);
  endtask

  task automatic pulse_ack;
    irq_ack = 1'b1;
    step;
    irq_ack = 1'b0;
    irq_m   = 1'b0;
    check("irq_clr", irq, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    int   snap;
    int   p0;
    int   w;
    int   ct;
    exp_t e;

    reset_n    = 1'b1;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    burstcount = '0;
    local_addr = '0;
    irq_ack    = 1'b0;
    irq_m      = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_wait", waitrequest, 32'd1);
    check("rst_rdv", readdatavalid, 32'd0);
    check("rst_rdata", readdata, 32'd0);
    check("rst_irq", irq, 32'd0);
    check("rst_local", local_rdata, 32'd0);
    #20 reset_n = 1'b1;
    step;
    check("post_rst_wait", waitrequest, 32'd0);

    // single write, local latency, single read
    bus_write(4, 1, 32'hDEADBEEF, 32'd0, 0);
    local_chk(4);
    bus_read(4, 1);

    // local read of a word written in the same cycle
    bus_write(30, 1, 32'h11, 32'd0, 0);
    local_addr = 8'd30;
    address    = 32'd30 << 2;
    burstcount = 5'd1;
    writedata  = 32'h22;
    write      = 1'b1;
    step;
    write   = 1'b0;
    mdl[30] = 32'h22;
    check("local_old", local_rdata, 32'h11);
    step;
    check("local_new", local_rdata, 32'h22);

    // fill 0..15 with k*3, 16-beat read, then bc=0
    bus_write(0, 16, 32'd0, 32'd3, 0);
    bus_read(0, 16);
    bus_read(0, 0);
    bus_read(15, 0);

    // read+write together: only the write happens
    snap       = n_rdv;
    address    = 32'd20 << 2;
    burstcount = 5'd1;
    writedata  = 32'h55;
    mdl[20]    = 32'h55;
    read       = 1'b1;
    write      = 1'b1;
    step;
    read  = 1'b0;
    write = 1'b0;
    check("rw_wait", waitrequest, 32'd0);
    step;
    step;
    step;
    check("rw_no_rdv", n_rdv - snap, 32'd0);
    local_chk(20);
    bus_read(20, 1);

    // wrapping write burst with a stall after beat 2
    pulse_ack;
    bus_write(DEPTH - 2, 4, 32'd1, 32'd1, 2);
    check("wrap_irq", irq, 32'd1);
    bus_read(DEPTH - 2, 4);
    local_chk(0);
    local_chk(1);
    local_chk(DEPTH - 1);

    // ack alone clears, ack with new set keeps irq
    pulse_ack;
    irq_ack = 1'b1;
    bus_write(DEPTH - 1, 1, 32'hA5, 32'd0, 0);
    irq_ack = 1'b0;
    check("ack_set_irq", irq, 32'd1);
    pulse_ack;
    step;
    check("irq_stays_clr", irq, 32'd0);

    // reset during a 10-beat read
    address    = '0;
    burstcount = 5'd10;
    read       = 1'b1;
    step;
    read = 1'b0;
    ct   = cyc;
    for (int i = 0; i < 10; i++) begin
      e.d = mdl[i];
      e.c = ct + 1 + i;
      exp_q.push_back(e);
    end
    p0 = n_pop;
    w  = 0;
    while (n_pop - p0 < 3 && w < 50) begin
      w++;
      step;
    end
    check("mid_beats", n_pop - p0, 32'd3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rdv", readdatavalid, 32'd0);
    check("mid_rst_wait", waitrequest, 32'd1);
    check("mid_rst_rdata", readdata, 32'd0);
    check("mid_rst_local", local_rdata, 32'd0);
    exp_q.delete();
    #10;
    reset_n = 1'b1;
    step;
    check("mid_post_wait", waitrequest, 32'd0);
    bus_read(0, 16);
    bus_read(DEPTH - 2, 2);
    bus_read(30, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
